// File: rtl/mtf_spike_decoder.sv
// Spike detector: hysteresis threshold + refractory on a sampled voltage; spike and event register 1 clk after the sample.
// Single-slot ISI event held until evt_ready; a spike arriving on a full slot is dropped and sets sticky overflow. Option: MTF_SPK_BURST_EN.
module mtf_spike_decoder #(
    parameter int W           = 16,
    parameter int ISI_W       = 16,
    parameter int REFRACT_CYC = 8
`ifdef MTF_SPK_BURST_EN
    , parameter int BURST_GAP = 1024
`endif
) (
    input  logic                clk,
    input  logic                reset,
    input  logic signed [W-1:0] v_in,
    input  logic                v_valid,
    input  logic signed [W-1:0] th_hi,
    input  logic signed [W-1:0] th_lo,
    output logic                spike,
    output logic                evt_valid,
    input  logic                evt_ready,
    output logic [ISI_W-1:0]    evt_isi,
    output logic                evt_first,
    output logic                evt_burst,
    output logic                overflow,
    output logic [1:0]          state
);

    localparam int RW = (REFRACT_CYC > 1) ? $clog2(REFRACT_CYC + 1) : 1;

    typedef enum logic [1:0] {
        BELOW   = 2'd0,
        ABOVE   = 2'd1,
        REFRACT = 2'd2,
        ILLEGAL = 2'd3
    } state_t;

    state_t           cur_st, nxt_st;
    logic [RW-1:0]    ref_cnt, ref_nxt;
    logic [ISI_W-1:0] isi_cnt;
    logic             first_pending;
    logic             spike_det;

    assign state = cur_st;

    always_comb begin
        nxt_st    = cur_st;
        ref_nxt   = ref_cnt;
        spike_det = 1'b0;
        case (cur_st)
            BELOW: begin
                if (v_valid && (v_in >= th_hi)) begin
                    nxt_st    = ABOVE;
                    spike_det = 1'b1;
                end
            end
            ABOVE: begin
                if (v_valid && (v_in < th_lo)) begin
                    if (REFRACT_CYC == 0) begin
                        nxt_st = BELOW;
                    end else begin
                        nxt_st  = REFRACT;
                        ref_nxt = RW'(REFRACT_CYC);
                    end
                end
            end
            REFRACT: begin
                // Leave on the clock the count reaches zero, so exactly REFRACT_CYC clks are spent here.
                if (ref_cnt != '0) ref_nxt = ref_cnt - RW'(1);
                if (ref_cnt <= RW'(1)) nxt_st = BELOW;
            end
            default: nxt_st = BELOW;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cur_st        <= BELOW;
            ref_cnt       <= '0;
            isi_cnt       <= '0;
            first_pending <= 1'b1;
            spike         <= 1'b0;
            evt_valid     <= 1'b0;
            evt_isi       <= '0;
            evt_first     <= 1'b0;
            overflow      <= 1'b0;
        end else begin
            cur_st  <= nxt_st;
            ref_cnt <= ref_nxt;
            spike   <= spike_det;
            if (v_valid) begin
                if (spike_det)
                    isi_cnt <= '0;
                else if (isi_cnt != '1)
                    isi_cnt <= isi_cnt + ISI_W'(1);
            end
            if (spike_det) begin
                first_pending <= 1'b0;
                if (!evt_valid || evt_ready) begin
                    evt_valid <= 1'b1;
                    evt_isi   <= isi_cnt;
                    evt_first <= first_pending;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

`ifdef MTF_SPK_BURST_EN
    always_ff @(posedge clk) begin
        if (reset)
            evt_burst <= 1'b0;
        else if (spike_det && (!evt_valid || evt_ready))
            evt_burst <= first_pending || (isi_cnt > ISI_W'(BURST_GAP));
    end
`else
    assign evt_burst = 1'b0;
`endif

endmodule

// File: tb/tb_mtf_spike_decoder.sv
// Directed bench for mtf_spike_decoder: inputs driven and outputs sampled 1 time unit after each rising clk.
module tb_mtf_spike_decoder;

`ifdef MTF_SPK_BURST_EN
    localparam bit BURST_ON = 1'b1;
`else
    localparam bit BURST_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic signed [15:0] v_in;
    logic               v_valid;
    logic signed [15:0] th_hi, th_lo;
    logic               spike, evt_valid, evt_ready, evt_first, evt_burst, overflow;
    logic [15:0]        evt_isi;
    logic [1:0]         state;

    int checks   = 0;
    int failures = 0;

    mtf_spike_decoder #(.W(16), .ISI_W(16), .REFRACT_CYC(8)) dut (
        .clk(clk), .reset(reset), .v_in(v_in), .v_valid(v_valid),
        .th_hi(th_hi), .th_lo(th_lo), .spike(spike), .evt_valid(evt_valid),
        .evt_ready(evt_ready), .evt_isi(evt_isi), .evt_first(evt_first),
        .evt_burst(evt_burst), .overflow(overflow), .state(state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input int v);
        v_in    = v[15:0];
        v_valid = 1'b1;
        tick();
        v_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1; v_valid = 1'b0; v_in = '0; evt_ready = 1'b0;
        th_hi = 16'sd100; th_lo = 16'sd50;
        idle(2);
        reset = 1'b0;
        checks++;
        if ({state, spike, evt_valid, evt_isi, evt_first, evt_burst, overflow} !== 23'd0) begin
            failures++;
            $display("FAIL reset_outputs: got state=%0d spike=%b vld=%b isi=%0d first=%b burst=%b ovf=%b, want all 0",
                     state, spike, evt_valid, evt_isi, evt_first, evt_burst, overflow);
        end
    endtask

    task automatic test_ramp();
        int nspk = 0;
        int spk_idx = -1;
        for (int i = 0; i <= 20; i++) begin
            feed(10 * i);
            if (spike) begin nspk++; spk_idx = i; end
        end
        for (int i = 19; i >= 0; i--) begin
            feed(10 * i);
            if (spike) nspk++;
        end
        checks++;
        if (nspk !== 1) begin failures++; $display("FAIL ramp_count: got %0d spikes, want 1", nspk); end
        checks++;
        if (spk_idx !== 10) begin failures++; $display("FAIL ramp_pos: spike after sample %0d, want 10 (v=100)", spk_idx); end
        checks++;
        if (evt_valid !== 1'b1 || evt_first !== 1'b1 || evt_isi !== 16'd10) begin
            failures++;
            $display("FAIL ramp_event: vld=%b first=%b isi=%0d, want 1 1 10", evt_valid, evt_first, evt_isi);
        end
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b0) begin failures++; $display("FAIL ramp_accept: evt_valid=%b, want 0", evt_valid); end
        idle(8);
    endtask

    task automatic test_isi_300();
        // 30 samples already counted since the first spike
        repeat (270) feed(0);
        feed(150);
        checks++;
        if (spike !== 1'b1 || evt_valid !== 1'b1 || evt_isi !== 16'd300 || evt_first !== 1'b0) begin
            failures++;
            $display("FAIL isi300_event: spike=%b vld=%b isi=%0d first=%b, want 1 1 300 0", spike, evt_valid, evt_isi, evt_first);
        end
        tick();
        checks++;
        if (evt_valid !== 1'b0 || spike !== 1'b0) begin
            failures++;
            $display("FAIL isi300_drain: vld=%b spike=%b, want 0 0", evt_valid, spike);
        end
        feed(0);
        idle(9);
    endtask

    task automatic test_refractory();
        int first_k = -1;
        feed(150);
        feed(40);
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL refr_enter: state=%0d, want 2", state); end
        for (int k = 1; k <= 12; k++) begin
            feed((k % 2 == 1) ? 120 : 40);
            if (spike && first_k < 0) first_k = k;
        end
        checks++;
        if (first_k !== 9) begin failures++; $display("FAIL refr_chatter: first spike at k=%0d, want 9", first_k); end
        idle(10);
        checks++;
        if (state !== 2'd0) begin failures++; $display("FAIL refr_exit: state=%0d, want 0", state); end
    endtask

    task automatic test_overflow();
        // 3 samples counted after the chatter spike, plus 5 more
        repeat (5) feed(0);
        evt_ready = 1'b0;
        feed(150);
        checks++;
        if (spike !== 1'b1 || evt_valid !== 1'b1 || evt_isi !== 16'd8 || overflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_first: spike=%b vld=%b isi=%0d ovf=%b, want 1 1 8 0", spike, evt_valid, evt_isi, overflow);
        end
        for (int s = 2; s <= 3; s++) begin
            feed(0);
            idle(9);
            feed(150);
            checks++;
            if (spike !== 1'b1 || evt_valid !== 1'b1 || evt_isi !== 16'd8 || overflow !== 1'b1) begin
                failures++;
                $display("FAIL ovf_drop%0d: spike=%b vld=%b isi=%0d ovf=%b, want 1 1 8 1", s, spike, evt_valid, evt_isi, overflow);
            end
        end
        feed(0);
        idle(9);
        evt_ready = 1'b1;
        tick();
        checks++;
        if (evt_valid !== 1'b0 || overflow !== 1'b1) begin
            failures++;
            $display("FAIL ovf_sticky: vld=%b ovf=%b, want 0 1", evt_valid, overflow);
        end
    endtask

    task automatic test_negative();
        th_hi = -16'sd20; th_lo = -16'sd80;
        feed(-100);
        checks++;
        if (spike !== 1'b0) begin failures++; $display("FAIL neg_below: spike=%b, want 0", spike); end
        feed(-10);
        checks++;
        if (spike !== 1'b1) begin failures++; $display("FAIL neg_spike: spike=%b, want 1", spike); end
        feed(-90);
        checks++;
        if (state !== 2'd2) begin failures++; $display("FAIL neg_refract: state=%0d, want 2", state); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if ({state, spike, evt_valid, evt_isi, evt_first, evt_burst, overflow} !== 23'd0) begin
            failures++;
            $display("FAIL neg_reset: state=%0d spike=%b vld=%b isi=%0d first=%b burst=%b ovf=%b, want all 0",
                     state, spike, evt_valid, evt_isi, evt_first, evt_burst, overflow);
        end
        // 5 >= -20 only under a signed compare
        feed(5);
        checks++;
        if (spike !== 1'b1 || evt_first !== 1'b1 || evt_isi !== 16'd0) begin
            failures++;
            $display("FAIL neg_signed: spike=%b first=%b isi=%0d, want 1 1 0", spike, evt_first, evt_isi);
        end
        feed(-90);
        idle(9);
    endtask

    task automatic test_misconfig();
        th_hi = 16'sd100; th_lo = 16'sd200;
        feed(150);
        checks++;
        if (spike !== 1'b1) begin failures++; $display("FAIL miscfg_spike: spike=%b, want 1", spike); end
        feed(150);
        checks++;
        if (state !== 2'd2 || spike !== 1'b0) begin
            failures++;
            $display("FAIL miscfg_exit: state=%0d spike=%b, want 2 0", state, spike);
        end
        idle(8);
        feed(150);
        checks++;
        if (spike !== 1'b1) begin failures++; $display("FAIL miscfg_repeat: spike=%b, want 1", spike); end
    endtask

    task automatic test_burst();
        int isis[3] = '{2000, 50, 50};
        bit exp_b;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        th_hi = 16'sd100; th_lo = 16'sd50; evt_ready = 1'b1;
        feed(150);
        checks++;
        if (evt_first !== 1'b1 || evt_burst !== BURST_ON) begin
            failures++;
            $display("FAIL burst_first: first=%b burst=%b, want 1 %b", evt_first, evt_burst, BURST_ON);
        end
        for (int j = 0; j < 3; j++) begin
            repeat (isis[j]) feed(0);
            feed(150);
            exp_b = BURST_ON && (j == 0);
            checks++;
            if (evt_valid !== 1'b1 || evt_isi !== 16'(isis[j]) || evt_burst !== exp_b) begin
                failures++;
                $display("FAIL burst_isi%0d: vld=%b isi=%0d burst=%b, want 1 %0d %b", j, evt_valid, evt_isi, evt_burst, isis[j], exp_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_isi_300();
        test_refractory();
        test_overflow();
        test_negative();
        test_misconfig();
        test_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
